// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder cell and a 1-bit carry register,
// LSB first, with a valid/ready operand handshake and a valid/ready result handshake.
// Optional subtraction is built when the SERIAL_ADDER_SUB_EN macro is defined.
module serial_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cmsb_q;
  logic             sub_q;
  logic             b_bit_c;
  logic             fa_sum_c;
  logic             fa_carry_c;
  logic             init_carry_c;

  // Carry seed on accept: subtraction forces 1 so that A + ~B + 1 = A - B.
  always_comb begin
    init_carry_c = in_cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (in_sub) begin
      init_carry_c = 1'b1;
    end
`endif
  end

  // Single full-adder cell on the current LSBs; B is inverted bit by bit when subtracting.
  always_comb begin
    b_bit_c    = b_q[0] ^ sub_q;
    fa_sum_c   = a_q[0] ^ b_bit_c ^ carry_q;
    fa_carry_c = (a_q[0] & b_bit_c) | (a_q[0] & carry_q) | (b_bit_c & carry_q);
  end

  // Control FSM, datapath shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      cmsb_q    <= 1'b0;
      sub_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= in_a;
            b_q      <= in_b;
            carry_q  <= init_carry_c;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q    <= in_sub;
`else
            sub_q    <= 1'b0;
`endif
            sum_q    <= '0;
            cnt_q    <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          a_q     <= {1'b0, a_q[WIDTH-1:1]};
          b_q     <= {1'b0, b_q[WIDTH-1:1]};
          sum_q   <= {fa_sum_c, sum_q[WIDTH-1:1]};
          carry_q <= fa_carry_c;
          if (cnt_q == CW'(WIDTH - 1)) begin
            // Carry entering the MSB cell, kept for signed overflow.
            cmsb_q <= carry_q;
            state  <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_sum   <= sum_q;
            out_cout  <= carry_q;
            out_ovf   <= carry_q ^ cmsb_q;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder against an arithmetic model.
module tb_serial_adder;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             busy;

  int total = 0;
  int bad   = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef SERIAL_ADDER_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic on the operands as presented at accept.
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub,
                       output logic [WIDTH-1:0] s, output logic co, output logic ov);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] bb;
    logic             c0;
    bb   = sub ? ~b : b;
    c0   = sub ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(c0);
    s    = full[WIDTH-1:0];
    co   = full[WIDTH];
    ov   = (a[WIDTH-1] == bb[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endtask

  // One complete transaction: accept, wait for the result, optional stall, handshake.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub, input int stall,
                        input bit scramble, input bit early_rdy);
    logic [WIDTH-1:0] es;
    logic             ec;
    logic             eo;
    int               lat;
    bit               seen;
    model(a, b, cin, sub, es, ec, eo);
    chk({tag, ":in_ready_idle"}, 64'(in_ready), 64'd1);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = early_rdy;
    chk({tag, ":busy_run"}, 64'(busy), 64'd1);
    chk({tag, ":in_ready_run"}, 64'(in_ready), 64'd0);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 4 * WIDTH; i++) begin
      if (scramble) begin
        in_a   = WIDTH'($urandom);
        in_b   = WIDTH'($urandom);
        in_cin = 1'($urandom);
        in_sub = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      if (lat == 3) chk({tag, ":sum_zero_run"}, 64'(out_sum), 64'd0);
    end
    if (!seen) begin
      chk({tag, ":timeout"}, 64'(out_valid), 64'd1);
    end else begin
      chk({tag, ":latency"}, 64'(lat), 64'(WIDTH + 1));
      chk({tag, ":sum"}, 64'(out_sum), 64'(es));
      chk({tag, ":cout"}, 64'(out_cout), 64'(ec));
      chk({tag, ":ovf"}, 64'(out_ovf), 64'(eo));
      if (!early_rdy) begin
        for (int i = 0; i < stall; i++) begin
          @(posedge clk); #1;
          chk({tag, ":stall_valid"}, 64'(out_valid), 64'd1);
          chk({tag, ":stall_sum"}, 64'(out_sum), 64'(es));
          chk({tag, ":stall_flags"}, 64'({out_cout, out_ovf}), 64'({ec, eo}));
          chk({tag, ":stall_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, ":valid_after_hs"}, 64'(out_valid), 64'd0);
      chk({tag, ":busy_after_hs"}, 64'(busy), 64'd0);
      chk({tag, ":in_ready_after_hs"}, 64'(in_ready), 64'd1);
      chk({tag, ":sum_after_hs"}, 64'(out_sum), 64'd0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(out_sum), 64'd0);
    chk("rst_flags", 64'({out_cout, out_ovf}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_op("ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_op("stall", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 10, 1'b0, 1'b0);
    run_op("scramble", 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    run_op("early_rdy", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 0, 1'b0, 1'b1);
`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    run_op("sub_pos", 32'd7, 32'd5, 1'b0, 1'b1, 0, 1'b0, 1'b0);
`endif

    // Abort mid-run with reset, then a clean operation.
    in_a     = 32'hAAAA_5555;
    in_b     = 32'h1357_9BDF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_sum", 64'(out_sum), 64'd0);
    run_op("after_abort", 32'd3, 32'd4, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      logic sub_r;
`ifdef SERIAL_ADDER_SUB_EN
      sub_r = 1'($urandom);
`else
      sub_r = 1'b0;
`endif
      run_op("random", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), sub_r,
             int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
